// File: rtl/camera_ctrl.sv
// camera_ctrl: frame controller for the 4-pixel camera.
// Runs one frame per init request: erase the array, expose it for
// exposure_time cycles, then hand over to the readout sequencer and wait
// for its finished flag. Owns the exposure-time register, which is stepped
// by exp_increase / exp_decrease while idle.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   init              start-frame request (IDLE only)
//   exp_increase      step exposure time up, saturating (IDLE only)
//   exp_decrease      step exposure time down, saturating (IDLE only)
//   readout_finished  finished flag from the readout sequencer
//   erase, expose     pixel array controls (never both high)
//   readout_enable    readout sequencer enable
//   readout_reset     readout sequencer reset
//   exposure_time     current exposure-time register
//   frame_done        one-cycle pulse on return to IDLE after a frame
module camera_ctrl #(
  parameter int unsigned EXP_W        = 5,
  parameter int unsigned EXP_MIN      = 2,
  parameter int unsigned EXP_MAX      = 30,
  parameter int unsigned EXP_DEFAULT  = 10,
  parameter int unsigned ERASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             exp_increase,
  input  logic             exp_decrease,
  input  logic             readout_finished,
  output logic             erase,
  output logic             expose,
  output logic             readout_enable,
  output logic             readout_reset,
  output logic [EXP_W-1:0] exposure_time,
  output logic             frame_done
);

  localparam int unsigned ERASE_W = $clog2(ERASE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ERASE   = 2'd1,
    EXPOSE  = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [ERASE_W-1:0] erase_cnt, erase_cnt_next;
  logic [EXP_W-1:0]   exp_cnt, exp_cnt_next;
  logic [EXP_W-1:0]   exp_time_next;
  logic               erase_next, expose_next, ro_en_next, ro_rst_next, done_next;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      erase_cnt      <= '0;
      exp_cnt        <= '0;
      exposure_time  <= EXP_W'(EXP_DEFAULT);
      erase          <= 1'b1;
      expose         <= 1'b0;
      readout_enable <= 1'b0;
      readout_reset  <= 1'b1;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_next;
      erase_cnt      <= erase_cnt_next;
      exp_cnt        <= exp_cnt_next;
      exposure_time  <= exp_time_next;
      erase          <= erase_next;
      expose         <= expose_next;
      readout_enable <= ro_en_next;
      readout_reset  <= ro_rst_next;
      frame_done     <= done_next;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_next     = state;
    erase_cnt_next = erase_cnt;
    exp_cnt_next   = exp_cnt;
    exp_time_next  = exposure_time;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        // Adjust is applied even on the init cycle so the frame sees it
        if (exp_increase && !exp_decrease && (exposure_time < EXP_W'(EXP_MAX))) begin
          exp_time_next = exposure_time + EXP_W'(1);
        end else if (exp_decrease && !exp_increase && (exposure_time > EXP_W'(EXP_MIN))) begin
          exp_time_next = exposure_time - EXP_W'(1);
        end
        if (init) begin
          state_next     = ERASE;
          erase_cnt_next = '0;
        end
      end

      ERASE: begin
        if (erase_cnt == ERASE_W'(ERASE_CYCLES - 1)) begin
          state_next   = EXPOSE;
          exp_cnt_next = exposure_time;
        end else begin
          erase_cnt_next = erase_cnt + ERASE_W'(1);
        end
      end

      EXPOSE: begin
        // Loaded with N, leaves after the cycle where it reads 1: N cycles
        if (exp_cnt <= EXP_W'(1)) begin
          state_next = READOUT;
        end else begin
          exp_cnt_next = exp_cnt - EXP_W'(1);
        end
      end

      READOUT: begin
        if (readout_finished) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Moore outputs decoded from the state being entered, then registered
    erase_next  = (state_next == IDLE) || (state_next == ERASE);
    expose_next = (state_next == EXPOSE);
    ro_en_next  = (state_next == READOUT);
    ro_rst_next = (state_next != READOUT);
  end

endmodule

// File: tb/tb_camera_ctrl.sv
// tb_camera_ctrl: randomized scoreboard bench for camera_ctrl.
// The driver keeps an exposure-time model and pushes one expected frame
// record per accepted init; the monitor measures each frame from the DUT
// outputs and checks it against the popped record on frame_done.
module tb_camera_ctrl;

  localparam int unsigned EXP_W        = 5;
  localparam int          EXP_MIN      = 2;
  localparam int          EXP_MAX      = 30;
  localparam int          EXP_DEFAULT  = 10;
  localparam int          ERASE_CYCLES = 2;
  localparam int          RO_LEN       = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             init;
  logic             exp_increase;
  logic             exp_decrease;
  logic             readout_finished;
  logic             erase;
  logic             expose;
  logic             readout_enable;
  logic             readout_reset;
  logic [EXP_W-1:0] exposure_time;
  logic             frame_done;

  camera_ctrl #(
    .EXP_W        (EXP_W),
    .EXP_MIN      (EXP_MIN),
    .EXP_MAX      (EXP_MAX),
    .EXP_DEFAULT  (EXP_DEFAULT),
    .ERASE_CYCLES (ERASE_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .exp_increase     (exp_increase),
    .exp_decrease     (exp_decrease),
    .readout_finished (readout_finished),
    .erase            (erase),
    .expose           (expose),
    .readout_enable   (readout_enable),
    .readout_reset    (readout_reset),
    .exposure_time    (exposure_time),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Readout sequencer stand-in: 8 enabled steps, finished held until reset.
  // stall masks finished to emulate a stuck sequencer.
  logic stall = 1'b0;
  int   seq_cnt;
  logic seq_fin;
  always @(posedge clk or posedge reset) begin
    if (reset || readout_reset) begin
      seq_cnt <= 0;
      seq_fin <= 1'b0;
    end else if (readout_enable && seq_cnt < 8) begin
      seq_cnt <= seq_cnt + 1;
      if (seq_cnt == 7) seq_fin <= 1'b1;
    end
  end
  assign readout_finished = seq_fin && !stall;

  typedef struct {
    int t_init;
    int exp_len;
    int ro_len;   // 0: length not predicted (stalled readout)
    int exp_time;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     model_exp;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int step_model(input int e, input bit inc, input bit dec);
    if (inc && !dec) return (e + 1 > EXP_MAX) ? EXP_MAX : e + 1;
    if (dec && !inc) return (e - 1 < EXP_MIN) ? EXP_MIN : e - 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures expose / readout windows and checks on frame_done
  initial begin : monitor
    bit p_exp = 0, p_ro = 0, p_fd = 0;
    int exp_start = 0, exp_len = 0, ro_start = 0, ro_len = 0;
    frame_t f;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_exp = 0; p_ro = 0; p_fd = 0;
      end else begin
        check("erase_expose_exclusive", int'(erase && expose), 0);
        check("enable_implies_no_reset", int'(readout_enable && readout_reset), 0);
        if (expose && !p_exp) begin exp_start = cyc; exp_len = 0; end
        if (expose) exp_len++;
        if (readout_enable && !p_ro) begin ro_start = cyc; ro_len = 0; end
        if (readout_enable) ro_len++;
        if (frame_done) begin
          check("frame_done_width", int'(p_fd), 0);
          if (!p_fd) begin
            check("frame_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              f = exp_q.pop_front();
              check("expose_start", exp_start, f.t_init + ERASE_CYCLES);
              check("expose_len", exp_len, f.exp_len);
              check("readout_start", ro_start, exp_start + exp_len);
              if (f.ro_len > 0) check("readout_len", ro_len, f.ro_len);
              check("done_after_readout", cyc, ro_start + ro_len);
              check("frame_exposure_time", int'(exposure_time), f.exp_time);
            end
          end
        end
        p_exp = expose;
        p_ro  = readout_enable;
        p_fd  = frame_done;
      end
    end
  end

  task automatic adjust(input bit inc, input bit dec, input int n);
    exp_increase = inc;
    exp_decrease = dec;
    repeat (n) begin
      tick();
      model_exp = step_model(model_exp, inc, dec);
      check("exposure_time", int'(exposure_time), model_exp);
    end
    exp_increase = 1'b0;
    exp_decrease = 1'b0;
  endtask

  task automatic run_frame(input bit noise, input bit do_stall, input bit adj_with_init);
    bit     inc, dec;
    frame_t f;
    int     n;
    inc = adj_with_init ? 1'($urandom_range(0, 1)) : 1'b0;
    dec = adj_with_init ? 1'($urandom_range(0, 1)) : 1'b0;
    stall        = do_stall;
    init         = 1'b1;
    exp_increase = inc;
    exp_decrease = dec;
    tick();
    model_exp  = step_model(model_exp, inc, dec);
    f.t_init   = cyc;
    f.exp_len  = model_exp;
    f.ro_len   = do_stall ? 0 : RO_LEN;
    f.exp_time = model_exp;
    exp_q.push_back(f);
    init         = 1'b0;
    exp_increase = 1'b0;
    exp_decrease = 1'b0;
    n = 0;
    if (do_stall) begin
      while (!readout_enable && n < 100) begin tick(); n++; end
      check("reach_readout", int'(readout_enable), 1);
      repeat (30) tick();
      check("stalled_enable", int'(readout_enable), 1);
      check("stalled_no_done", int'(frame_done), 0);
      stall = 1'b0;
      tick();
      check("done_after_finished", int'(frame_done), 1);
    end else begin
      while (!frame_done && n < 200) begin
        tick();
        n++;
        if (noise && !frame_done) begin
          init         = 1'($urandom_range(0, 1));
          exp_increase = 1'($urandom_range(0, 1));
          exp_decrease = 1'($urandom_range(0, 1));
        end
      end
      init         = 1'b0;
      exp_increase = 1'b0;
      exp_decrease = 1'b0;
      check("frame_completed", int'(frame_done), 1);
    end
    if (!frame_done) exp_q.delete();
    check("exp_after_frame", int'(exposure_time), model_exp);
  endtask

  initial begin : driver
    reset        = 1'b1;
    init         = 1'b0;
    exp_increase = 1'b0;
    exp_decrease = 1'b0;
    model_exp    = EXP_DEFAULT;
    #1;
    check("in_reset_erase", int'(erase), 1);
    check("in_reset_readout_reset", int'(readout_reset), 1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) tick();
    check("rst_erase", int'(erase), 1);
    check("rst_expose", int'(expose), 0);
    check("rst_readout_enable", int'(readout_enable), 0);
    check("rst_readout_reset", int'(readout_reset), 1);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_exposure_time", int'(exposure_time), EXP_DEFAULT);

    run_frame(1'b0, 1'b0, 1'b0);           // baseline frame

    adjust(1'b1, 1'b0, 40);                // saturate high
    adjust(1'b1, 1'b1, 5);                 // both high: hold
    adjust(1'b0, 1'b1, 40);                // saturate low
    run_frame(1'b0, 1'b0, 1'b0);           // minimum exposure frame
    adjust(1'b1, 1'b0, 8);                 // back to default
    run_frame(1'b1, 1'b0, 1'b0);           // inputs toggled mid-frame
    run_frame(1'b0, 1'b1, 1'b0);           // stalled readout

    // Reset during cycle 4 of EXPOSE
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (ERASE_CYCLES + 3) tick();
    check("mid_expose_before_reset", int'(expose), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_expose", int'(expose), 0);
    check("async_rst_erase", int'(erase), 1);
    check("async_rst_readout_reset", int'(readout_reset), 1);
    check("async_rst_readout_enable", int'(readout_enable), 0);
    check("async_rst_exposure_time", int'(exposure_time), EXP_DEFAULT);
    exp_q.delete();
    model_exp = EXP_DEFAULT;
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 1'b0);

    // Randomized adjust / frame mix
    repeat (25) begin
      adjust(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 2) == 0) run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    repeat (3) tick();
    check("pending_frames_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_ctrl.md
# camera_ctrl

Top-level frame controller for the 4-pixel camera. Sits directly upstream of the readout sequencer: on an `init` request it erases the pixel array, exposes it for a programmable number of cycles, then enables the readout sequencer and waits for its `finished` flag before returning to idle. It also owns the user-adjustable exposure-time register, stepped by increase/decrease inputs while idle.

## Interface

Parameters:
- `EXP_W`, 5, width of the exposure-time register and counter.
- `EXP_MIN`, 2, minimum exposure time in cycles; must be ≥ 1.
- `EXP_MAX`, 30, maximum exposure time in cycles; must be ≤ 2^EXP_W − 1.
- `EXP_DEFAULT`, 10, exposure time after reset; must satisfy EXP_MIN ≤ EXP_DEFAULT ≤ EXP_MAX.
- `ERASE_CYCLES`, 2, length of the ERASE state in cycles; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `init`  in  1  start-frame request; sampled only in IDLE.
- `exp_increase`  in  1  raise exposure time by 1 per cycle while high; sampled only in IDLE.
- `exp_decrease`  in  1  lower exposure time by 1 per cycle while high; sampled only in IDLE.
- `readout_finished`  in  1  `finished` output of the readout sequencer.
- `erase`  out  1  pixel erase control.
- `expose`  out  1  pixel expose control.
- `readout_enable`  out  1  drives the readout sequencer `enable`.
- `readout_reset`  out  1  drives the readout sequencer `reset`.
- `exposure_time`  out  EXP_W  current exposure-time register.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation

- States: IDLE, ERASE, EXPOSE, READOUT. Outputs are registered and decoded from the state (Moore); no combinational path from inputs to outputs.
- Reset (asynchronous, takes effect immediately while `reset` is high):
  - state = IDLE, `exposure_time` = EXP_DEFAULT, counters = 0.
  - `erase`=1, `expose`=0, `readout_enable`=0, `readout_reset`=1, `frame_done`=0.
- IDLE:
  - `erase`=1, `readout_reset`=1.
  - Exposure adjust:
    - `exp_increase`=1 and `exp_decrease`=0 → `exposure_time`+1, saturating at EXP_MAX.
    - `exp_decrease`=1 and `exp_increase`=0 → `exposure_time`−1, saturating at EXP_MIN.
    - Both high → no change.
  - `init`=1 → ERASE. When `init` and an adjust input are high in the same cycle, the adjust is applied as well, and the frame uses the updated value.
- ERASE:
  - `erase`=1, `readout_reset`=1.
  - Stays for exactly ERASE_CYCLES cycles, then goes to EXPOSE.
  - On entry to EXPOSE, the exposure counter loads `exposure_time`.
- EXPOSE:
  - `expose`=1, `erase`=0, `readout_reset`=1.
  - Counter decrements each cycle; when it reaches 1 → READOUT.
  - `expose` is high for exactly `exposure_time` cycles.
- READOUT:
  - `readout_reset`=0, `readout_enable`=1, `erase`=0, `expose`=0.
  - `readout_finished`=1 → IDLE, with `frame_done`=1 for that single first IDLE cycle.
  - No timeout; a stuck readout is cleared only by `reset`.
- Ignored inputs:
  - `init`, `exp_increase`, `exp_decrease` are ignored outside IDLE.
  - `readout_finished` is ignored outside READOUT. It is normally still high at IDLE entry, until `readout_reset` clears the sequencer.
- `erase` and `expose` are never both high.
- `readout_enable`=1 implies `readout_reset`=0.

## Timing

- `init` sampled high at edge T (state IDLE):
  - `erase` high from T+1 through T+ERASE_CYCLES (continuing the IDLE high level).
  - `expose` high from T+ERASE_CYCLES+1 for `exposure_time` cycles.
  - `readout_enable` high from the next edge until the edge after `readout_finished` is sampled.
- With the current sequencer (8 enabled steps), READOUT lasts 9 cycles.
- Full frame with defaults, from the `init` edge to `frame_done`: 2 + 10 + 9 + 1 cycles.
- Exposure adjust latency: 1 cycle; one step per cycle while the input is held.
- Reset asserted mid-frame: outputs return to reset values asynchronously. `readout_reset`=1 clears the sequencer, and `exposure_time` returns to EXP_DEFAULT.

## Test plan

- Reset release, no input for 5 cycles → state IDLE, `erase`=1, `readout_reset`=1, `exposure_time`=10, all other outputs 0.
- `init` pulse for 1 cycle with defaults and the real sequencer attached:
  - `erase` high 2 further cycles, then `expose` high exactly 10 cycles.
  - Then `readout_enable` high 9 cycles, then a single `frame_done` pulse.
- Saturation:
  - Hold `exp_increase` for 40 cycles → `exposure_time` stops at 30.
  - Hold `exp_decrease` for 40 cycles → stops at 2.
  - Both high together → value unchanged.
  - With `exposure_time`=2, a frame has `expose` high exactly 2 cycles.
- Inputs outside IDLE: pulse `init`, `exp_increase`, `exp_decrease` during EXPOSE and READOUT → no restart, `exposure_time` unchanged, frame timing identical to the baseline.
- Reset mid-EXPOSE (cycle 4 of 10) → `expose` drops within the same cycle, IDLE outputs are restored, and a subsequent `init` produces a full baseline frame.
- `readout_finished` held low indefinitely via a stub → the block stays in READOUT with `readout_enable`=1. Asserting `readout_finished` → IDLE on the next edge with `frame_done`=1.
